fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch front end that feeds the decode/control stage.
- Owns the PC register and issues word-aligned read requests to instruction memory over a valid/ready request channel.
- Captures the returned instruction word and presents it to control until control advances with pc_sel_next.
- Accepts a PC redirect input for future branch/jump support, and reports fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- NOP_INSTR, 32'h0000_0013, word driven on instr_o while instr_valid_o=0 (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- imem_req_valid_o  out  1  read request valid
- imem_req_ready_i  in  1  memory accepts request this cycle
- imem_addr_o  out  32  request address (always the current fetch PC)
- imem_rsp_valid_i  in  1  response word valid (one cycle per accepted request)
- imem_rsp_data_i  in  32  response instruction word
- imem_rsp_err_i  in  1  response is a bus error (qualified by imem_rsp_valid_i)
- pc_sel_next_i  in  1  from control: 0 = hold current instruction, 1 = advance PC+4
- redirect_valid_i  in  1  load redirect_pc_i as next fetch PC
- redirect_pc_i  in  32  redirect target
- instr_valid_o  out  1  instr_o holds a fetched instruction
- instr_o  out  32  instruction word to control (pc_data)
- pc_o  out  32  PC of instr_o
- fault_o  out  1  fetch fault latched

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- At most one outstanding request; a response always corresponds to the last accepted request.
- Reset values:
  - state=ST_REQ, pc=RESET_PC
  - instr_valid_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC
  - imem_req_valid_o=0 in the reset cycle; it asserts on the first cycle after rst_i deasserts.
  - fault_o=0, drop flag=0
  - Reset mid-transaction discards any pending response.
- States:
  - ST_REQ:
    - imem_req_valid_o=1, imem_addr_o=pc.
    - Handshake when valid & ready: go to ST_WAIT.
    - Address is held stable while ready=0.
  - ST_WAIT:
    - imem_req_valid_o=0; wait for imem_rsp_valid_i.
    - On a good response with drop=0: latch instr_o=data and pc_o=pc, set instr_valid_o=1, go to ST_HOLD.
    - On err with drop=0: set fault_o=1, go to ST_FAULT.
    - On any response with drop=1: clear drop, discard the word, go to ST_REQ.
  - ST_HOLD:
    - instr_valid_o=1.
    - If pc_sel_next_i=1: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), instr_valid_o<=0, go to ST_REQ.
    - Otherwise hold all outputs.
  - ST_FAULT:
    - imem_req_valid_o=0, instr_valid_o=0, fault_o=1.
    - Exit only by an aligned redirect.
- Latency: from ST_REQ entry with ready=1 and a 1-cycle memory, instr_valid_o rises 2 cycles later.
- Redirect (priority over pc_sel_next_i and over the response in the same cycle):
  - redirect_pc_i[1:0]!=0: set fault_o=1, go to ST_FAULT, instr_valid_o<=0.
  - In ST_REQ, ST_HOLD or ST_FAULT: pc<=redirect_pc_i, instr_valid_o<=0, fault_o<=0, go to ST_REQ.
  - In ST_REQ on the same cycle as an accepted handshake: the accepted request becomes stale; set drop=1, go to ST_WAIT with pc<=target.
  - In ST_WAIT with no response this cycle: pc<=target, drop<=1, stay in ST_WAIT.
  - In ST_WAIT with a response this cycle: discard the response, go to ST_REQ with pc<=target.
- instr_o=NOP_INSTR whenever instr_valid_o=0, so control decodes a harmless word when nothing valid is presented.
- pc_sel_next_i is ignored outside ST_HOLD.
- imem_rsp_valid_i outside ST_WAIT is ignored; the bench flags it as a protocol violation.

Decomposition:
- The team's shared constants file gets `FETCH_NOP (32'h0000_0013) and the PC increment constant 4.
- State encoding stays as a local parameter set in the module: ST_REQ, ST_WAIT, ST_HOLD, ST_FAULT.
- No sub-module; the PC adder and next-state logic are a single combinational block with one registered state block.

Test Plan:
- Reset then ready=1, 1-cycle memory returning 32'h1234_50B7 at addr 0 → req at 0x0, instr_valid_o=1 two cycles later, instr_o=32'h1234_50B7, pc_o=0.
- Hold pc_sel_next_i=0 for 5 cycles in ST_HOLD → outputs unchanged and no new request. Then pulse 1 → next request at addr 0x4.
- imem_req_ready_i low for 3 cycles → imem_req_valid_o stays 1 with addr stable. Handshake happens on the 4th cycle.
- Redirect to 0x100 while in ST_WAIT, then response 0xDEAD_BEEF arrives → word discarded, instr_valid_o stays 0, next request at 0x100.
- Response with imem_rsp_err_i=1 → fault_o=1 and requests stop. Redirect to 0x2 keeps the fault; redirect to 0x40 clears it and a request issues at 0x40.
- With pc=0xFFFF_FFFC, advance → next request at 0x0000_0000. Assert rst_i in ST_WAIT and let a response arrive → all reset values, response ignored, fresh request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants: the decoder-safe filler word and the sequential PC step.
package fetch_unit_pkg;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word read at a time and
// presents the returned word to control until control advances or redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    input  logic        pc_sel_next_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state,       w_state;
    logic [31:0] r_pc,          w_pc;
    logic [31:0] r_pc_out,      w_pc_out;
    logic [31:0] r_instr,       w_instr;
    logic        r_instr_valid, w_instr_valid;
    logic        r_fault,       w_fault;
    logic        r_drop,        w_drop;
    logic        r_req_valid,   w_req_valid;
    logic        w_handshake;

    assign w_handshake = r_req_valid & imem_req_ready_i;

    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_pc_out      = r_pc_out;
        w_instr       = r_instr;
        w_instr_valid = r_instr_valid;
        w_fault       = r_fault;
        w_drop        = r_drop;

        if (redirect_valid_i) begin
            if (!is_word_aligned(redirect_pc_i)) begin
                w_state       = ST_FAULT;
                w_fault       = 1'b1;
                w_instr_valid = 1'b0;
            end else begin
                w_pc          = redirect_pc_i;
                w_instr_valid = 1'b0;
                w_fault       = 1'b0;
                case (r_state)
                    // A request already on the bus must have its response thrown away.
                    ST_REQ: begin
                        if (w_handshake) begin
                            w_state = ST_WAIT;
                            w_drop  = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rsp_valid_i) begin
                            w_state = ST_REQ;
                            w_drop  = 1'b0;
                        end else begin
                            w_drop  = 1'b1;
                        end
                    end
                    default: w_state = ST_REQ;
                endcase
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_handshake) w_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (r_drop) begin
                            w_drop  = 1'b0;
                            w_state = ST_REQ;
                        end else if (imem_rsp_err_i) begin
                            w_fault = 1'b1;
                            w_state = ST_FAULT;
                        end else begin
                            w_instr       = imem_rsp_data_i;
                            w_pc_out      = r_pc;
                            w_instr_valid = 1'b1;
                            w_state       = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (pc_sel_next_i) begin
                        w_pc          = r_pc + PC_INC;
                        w_instr_valid = 1'b0;
                        w_state       = ST_REQ;
                    end
                end
                default: ;
            endcase
        end

        // Request valid is registered so it follows the state it will be asserted in.
        w_req_valid = (w_state == ST_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_pc_out      <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_drop        <= 1'b0;
            r_req_valid   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_pc_out      <= w_pc_out;
            r_instr       <= w_instr;
            r_instr_valid <= w_instr_valid;
            r_fault       <= w_fault;
            r_drop        <= w_drop;
            r_req_valid   <= w_req_valid;
        end
    end

    assign imem_req_valid_o = r_req_valid;
    assign imem_addr_o      = r_pc;
    assign instr_valid_o    = r_instr_valid;
    assign instr_o          = r_instr_valid ? r_instr : NOP_INSTR;
    assign pc_o             = r_pc_out;
    assign fault_o          = r_fault;

endmodule
